// File: rtl/jk_pkg.sv
// Shared constants for the JK-flip-flop based modulo counter: JK excitation modes
// and the default counter geometry.
package jk_pkg;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  localparam int unsigned DefaultWidth   = 4;
  localparam int unsigned DefaultModulus = 10;

endpackage

// File: rtl/jk_ff.sv
// Generic JK flip-flop with asynchronous active-low reset; knows nothing about counting.
module jk_ff
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d, q_q;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      HOLD:   q_d = q_q;
      RESET:  q_d = 1'b0;
      SET:    q_d = 1'b1;
      TOGGLE: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter with parallel load, whose state lives only in
// WIDTH JK flip-flops driven through JK excitation of the combinational next value.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned MODULUS = DefaultModulus
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModWide = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] n_d;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             d_legal;
  logic             q_legal;

  // Compare one bit wider so MODULUS == 2**WIDTH stays representable.
  always_comb begin
    d_legal = ({1'b0, d} < ModWide);
    q_legal = ({1'b0, q_q} < ModWide);
    n_d     = q_q;
    if (load) begin
      n_d = d_legal ? d : '0;
    end else if (en) begin
      if (!q_legal) begin
        n_d = '0;
      end else if (up) begin
        n_d = (q_q == MaxVal) ? '0 : q_q + WIDTH'(1);
      end else begin
        n_d = (q_q == '0) ? MaxVal : q_q - WIDTH'(1);
      end
    end
  end

  // Excitation: unchanged bits get J=K=0, so hold is free.
  assign j = ~q_q & n_d;
  assign k = q_q & ~n_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_jk_ff (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q_q[i])
    );
  end

  assign q  = q_q;
  assign tc = rst & en & ~load & ((up & (q_q == MaxVal)) | (~up & (q_q == '0)));

endmodule
